// File: rtl/mult_seq_core_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;
  localparam int WIDTH = 8;
  localparam int LAT   = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/mult_seq_core_if.sv
// Start/operand/result bundle between the tile top and the multiplier core.
interface mult_seq_core_if #(parameter int WIDTH = mult_pkg::WIDTH);
  logic               start;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, op_a, op_b, input busy, done, product);
  modport slave  (input start, op_a, op_b, output busy, done, product);
endinterface

// File: rtl/mult_seq_core_abs.sv
// Two's-complement magnitude and sign extraction; used only when MULT_SIGNED_EN is defined.
module mult_abs #(parameter int WIDTH = 8) (
  input  logic [WIDTH-1:0] val,
  output logic [WIDTH-1:0] mag,
  output logic             neg
);
  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  always_comb begin
    neg = val[WIDTH-1];
    if (neg) begin
      mag = ~val + WIDTH'(1);
    end else begin
      mag = val;
    end
  end
endmodule

// File: rtl/mult_seq_core.sv
// Shift-and-add WIDTH x WIDTH multiplier, one multiplier bit per cycle, fixed latency.
// Optional macro MULT_SIGNED_EN selects two's-complement operands.
module mult_seq_core
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  mult_seq_core_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t               state_r, state_next;
  logic [WIDTH-1:0]     mcand_r, mplier_r;
  logic [2*WIDTH:0]     acc_r;
  logic [CW-1:0]        count_r;
  logic                 busy_r, done_r;
  logic [2*WIDTH-1:0]   product_r;
  logic [WIDTH-1:0]     mag_a_s, mag_b_s;
  logic [WIDTH:0]       sum_s;
  logic [2*WIDTH:0]     acc_shift_s;
  logic [2*WIDTH-1:0]   product_next_s;
  logic                 last_s;

`ifdef MULT_SIGNED_EN
  logic neg_a_s, neg_b_s, sign_r;
  mult_abs #(.WIDTH(WIDTH)) u_abs_a (.val(bus.op_a), .mag(mag_a_s), .neg(neg_a_s));
  mult_abs #(.WIDTH(WIDTH)) u_abs_b (.val(bus.op_b), .mag(mag_b_s), .neg(neg_b_s));
`else
  assign mag_a_s = bus.op_a;
  assign mag_b_s = bus.op_b;
`endif

  assign last_s = (count_r == CW'(WIDTH - 1));

  // Add multiplicand into the upper half when the multiplier LSB is set, then shift right.
  always_comb begin
    if (mplier_r[0]) begin
      sum_s = acc_r[2*WIDTH:WIDTH] + {1'b0, mcand_r};
    end else begin
      sum_s = acc_r[2*WIDTH:WIDTH];
    end
    acc_shift_s = {1'b0, sum_s, acc_r[WIDTH-1:1]};
  end

  // Final result selection from the accumulator.
  always_comb begin
`ifdef MULT_SIGNED_EN
    if (sign_r) begin
      product_next_s = -acc_r[2*WIDTH-1:0];
    end else begin
      product_next_s = acc_r[2*WIDTH-1:0];
    end
`else
    product_next_s = acc_r[2*WIDTH-1:0];
`endif
  end

  // Next-state logic; ena low holds the current state.
  always_comb begin
    state_next = state_r;
    if (!ena) begin
      state_next = state_r;
    end else begin
      case (state_r)
        IDLE:    state_next = bus.start ? CALC : IDLE;
        CALC:    state_next = last_s ? DONE : CALC;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Datapath and registered status outputs, all frozen while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r   <= '0;
      mplier_r  <= '0;
      acc_r     <= '0;
      count_r   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
`ifdef MULT_SIGNED_EN
      sign_r    <= 1'b0;
`endif
    end else if (ena) begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            mcand_r  <= mag_a_s;
            mplier_r <= mag_b_s;
            acc_r    <= '0;
            count_r  <= '0;
`ifdef MULT_SIGNED_EN
            sign_r   <= neg_a_s ^ neg_b_s;
`endif
          end
        end
        CALC: begin
          acc_r    <= acc_shift_s;
          mplier_r <= mplier_r >> 1;
          count_r  <= count_r + CW'(1);
        end
        DONE:    product_r <= product_next_s;
        default: ;
      endcase
      busy_r <= (state_next == CALC);
      done_r <= (state_r == DONE);
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;
endmodule
